pc_unit: RTL

- Parametrised program-counter unit; next generation of the plain PC register.
- Owns the fetch address register and selects the next PC from several sources: sequential, branch, jump, return, exception and exception-return.
- Adds stall, an exception-PC (EPC) register and a circular return-address stack (RAS).
- Sits at the head of the fetch stage; drives the instruction-memory address.

---
 rtl/pc_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: fetch address register with branch, jump, return,
// exception handling, EPC and a circular return-address stack.
module pc_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = 'h80,
  parameter int unsigned STEP      = 4,
  parameter int unsigned OFFSET_W  = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic                jump,
  input  logic [WIDTH-1:0]    jump_target,
  input  logic                call,
  input  logic                ret,
  input  logic                exc,
  input  logic                eret,
  output logic [WIDTH-1:0]    pc,
  output logic [WIDTH-1:0]    pc_plus,
  output logic [WIDTH-1:0]    epc,
  output logic                in_exc,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_underflow
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] ALIGN = ~WIDTH'(3);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [PW-1:0]    top_idx;
  logic [WIDTH-1:0] pc_d, epc_d;
  logic             exc_d, uf_d, push;
  logic [WIDTH-1:0] br_sext, br_tgt;

  assign pc_plus   = pc + WIDTH'(STEP);
  assign top_idx   = ptr_q - PW'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == (PW+1)'(RAS_DEPTH));
  assign br_sext   = WIDTH'($signed(br_offset));
  assign br_tgt    = (pc_plus + (br_sext << 2)) & ALIGN;

  always_comb begin
    pc_d  = pc_plus;
    epc_d = epc;
    exc_d = in_exc;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    uf_d  = 1'b0;
    push  = 1'b0;
    priority case (1'b1)
      exc: begin
        pc_d  = EXC_VEC;
        exc_d = 1'b1;
        if (!in_exc) epc_d = pc;
      end
      eret && in_exc: begin
        pc_d  = epc & ALIGN;
        exc_d = 1'b0;
      end
      stall: pc_d = pc;
      ret: begin
        if (ras_empty) begin
          uf_d = 1'b1;
        end else begin
          pc_d  = ras_q[top_idx] & ALIGN;
          ptr_d = top_idx;
          cnt_d = cnt_q - 1'b1;
        end
      end
      jump: begin
        pc_d = jump_target & ALIGN;
        if (call) begin
          // Full stack: the write slot is the oldest entry
          push  = 1'b1;
          ptr_d = ptr_q + PW'(1);
          if (!ras_full) cnt_d = cnt_q + 1'b1;
        end
      end
      br_taken: pc_d = br_tgt;
      default: pc_d = pc_plus;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_VEC;
      epc           <= '0;
      in_exc        <= 1'b0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_d;
      epc           <= epc_d;
      in_exc        <= exc_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      ras_underflow <= uf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= pc_plus;
  end

endmodule
